// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Load-use, branch and multi-cycle FPU stall/flush sequencer
//               for the 5-stage RV32IF pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
    parameter int LAT_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_EX,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic             RegWriteF_EX,
    input  logic             PCSrc_EX,
    input  logic             FpuStart_EX,
    input  logic [LAT_W-1:0] FpuLat_EX,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FpuBusy,
    output logic             FpuDone,
    output logic [CNT_W-1:0] StallCycles
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [LAT_W-1:0] c_LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] c_LAT_TWO = LAT_W'(2);

    logic [1:0]       r_state;
    logic [LAT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_fstart;
    logic w_fhold;
    logic w_rd_writes;
    logic w_rd_match;
    logic w_lu;
    logic w_branch;

    assign w_fstart = (r_state == c_S_IDLE) && FpuStart_EX && (FpuLat_EX >= c_LAT_TWO);
    assign w_fhold  = w_fstart || (r_state == c_S_BUSY);

    // Float f0 is a real register, so only the integer-write path excludes rd==0.
    assign w_rd_writes = (RegWrite_EX && (Rd_EX != 5'd0)) || RegWriteF_EX;
    assign w_rd_match  = (Rd_EX == Rs1_D) || (Rd_EX == Rs2_D);
    assign w_lu        = MemRead_EX && !w_fhold && w_rd_writes && w_rd_match;
    assign w_branch    = PCSrc_EX && !w_fhold;

    assign StallF      = w_fhold || w_lu;
    assign StallD      = w_fhold || w_lu;
    assign StallE      = w_fhold;
    assign FlushD      = w_branch;
    assign FlushE      = w_lu || w_branch;
    assign FlushM      = w_fhold;
    assign FpuBusy     = (r_state == c_S_BUSY);
    assign FpuDone     = (r_state == c_S_DONE);
    assign StallCycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_fstart) begin
                        r_cnt   <= FpuLat_EX - c_LAT_TWO;
                        r_state <= (FpuLat_EX == c_LAT_TWO) ? c_S_DONE : c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    if (r_cnt == c_LAT_ONE) begin
                        r_state <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_LAT_ONE;
                    end
                end
                // The instruction still sitting in EX during DONE is the finished op.
                c_S_DONE: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (StallD) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed plus randomized bench for hazard_control_unit against
//               a cycle-timestamp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1_D, Rs2_D, Rd_EX;
    logic        MemRead_EX, RegWrite_EX, RegWriteF_EX, PCSrc_EX, FpuStart_EX;
    logic [4:0]  FpuLat_EX;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, FpuBusy, FpuDone;
    logic [31:0] StallCycles;

    int total = 0;
    int bad   = 0;

    // Reference model: an accepted op is remembered by its entry cycle and latency.
    int          cyc_n  = 0;
    bit          op_act = 1'b0;
    int          op_t   = 0;
    int          op_n   = 0;
    logic [31:0] m_cnt  = 32'd0;
    logic [31:0] r_base;

    always #5 clk = ~clk;

    hazard_control_unit #(.LAT_W(5), .CNT_W(32)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .Rd_EX        (Rd_EX),
        .MemRead_EX   (MemRead_EX),
        .RegWrite_EX  (RegWrite_EX),
        .RegWriteF_EX (RegWriteF_EX),
        .PCSrc_EX     (PCSrc_EX),
        .FpuStart_EX  (FpuStart_EX),
        .FpuLat_EX    (FpuLat_EX),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .FpuBusy      (FpuBusy),
        .FpuDone      (FpuDone),
        .StallCycles  (StallCycles)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return op_act && (cyc_n >= op_t + 1) && (cyc_n <= op_t + op_n - 2);
    endfunction

    function automatic bit m_done();
        return op_act && (cyc_n == op_t + op_n - 1);
    endfunction

    task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit mr, input bit rw, input bit rwf,
                        input bit pc, input bit fs, input logic [4:0] lat);
        bit fstart, fhold, lu, br, busy, done;
        logic [7:0] exp_ctl;
        @(negedge clk);
        reset = rst; Rs1_D = rs1; Rs2_D = rs2; Rd_EX = rd;
        MemRead_EX = mr; RegWrite_EX = rw; RegWriteF_EX = rwf;
        PCSrc_EX = pc; FpuStart_EX = fs; FpuLat_EX = lat;
        #1;
        busy    = m_busy();
        done    = m_done();
        fstart  = !busy && !done && fs && (lat >= 2);
        fhold   = fstart || busy;
        lu      = mr && !fhold && ((rw && rd != 0) || rwf) && (rd == rs1 || rd == rs2);
        br      = pc && !fhold;
        exp_ctl = {fhold | lu, fhold | lu, fhold, br, lu | br, fhold, busy, done};
        check_val("ctl", {24'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM, FpuBusy, FpuDone},
                  {24'd0, exp_ctl});
        check_val("stall_cycles", StallCycles, m_cnt);
        @(posedge clk);
        if (rst) begin
            op_act = 1'b0;
            m_cnt  = 32'd0;
        end else begin
            if (fstart) begin
                op_act = 1'b1;
                op_t   = cyc_n;
                op_n   = int'(lat);
            end
            if (fhold || lu) m_cnt = m_cnt + 32'd1;
        end
        cyc_n++;
        if (op_act && cyc_n >= op_t + op_n) op_act = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic fpu(input int cycles, input logic [4:0] lat);
        for (int i = 0; i < cycles; i++) step(0, 1, 2, 3, 0, 0, 1, 0, 1, lat);
    endtask

    initial begin
        reset = 1'b1; Rs1_D = 0; Rs2_D = 0; Rd_EX = 0; MemRead_EX = 0; RegWrite_EX = 0;
        RegWriteF_EX = 0; PCSrc_EX = 0; FpuStart_EX = 0; FpuLat_EX = 0;
        repeat (2) @(posedge clk);
        idle(1);

        // Integer load-use, then the same against x0.
        step(0, 5, 7, 5, 1, 1, 0, 0, 0, 5'd0);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0, 5'd0);
        // Float load into f0 consumed by the ID instruction.
        step(0, 3, 0, 0, 1, 0, 1, 0, 0, 5'd0);
        // Taken branch.
        step(0, 4, 4, 4, 0, 1, 0, 1, 0, 5'd0);
        idle(1);

        r_base = StallCycles;
        fpu(5, 5'd5);
        idle(1);
        check_val("fpu5_stalls", StallCycles - r_base, 32'd4);

        r_base = StallCycles;
        fpu(2, 5'd2);
        fpu(1, 5'd1);
        idle(1);
        check_val("fpu2_stalls", StallCycles - r_base, 32'd1);

        r_base = StallCycles;
        fpu(8, 5'd4);
        idle(1);
        check_val("b2b_stalls", StallCycles - r_base, 32'd6);

        // Longest supported latency.
        fpu(31, 5'd31);
        idle(1);

        // Load-use match during BUSY, then a reset that abandons the op.
        fpu(2, 5'd10);
        step(0, 6, 0, 6, 1, 1, 0, 1, 0, 5'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] lat;
            lat = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 7));
            step($urandom_range(0, 99) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) == 0, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and multi-cycle FPU sequencer for the 5-stage RV32IF core. It generates the stall and flush controls that operand forwarding cannot cover. These are load-use hazards on integer and float registers, control hazards from a branch or jump resolved in EX, and holding EX while a multi-cycle FPU operation (FDIV, FSQRT, etc.) iterates. It sits beside the forwarding unit and drives the enables and clears of the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- LAT_W, 5: width of the FPU latency field.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- Rs1_D  in  5  rs1 of the instruction in ID
- Rs2_D  in  5  rs2 of the instruction in ID
- Rd_EX  in  5  rd of the instruction in EX
- MemRead_EX  in  1  EX instruction is a load (LW or FLW)
- RegWrite_EX  in  1  EX instruction writes the integer register file
- RegWriteF_EX  in  1  EX instruction writes the float register file
- PCSrc_EX  in  1  taken branch or jump resolved in EX
- FpuStart_EX  in  1  level; the EX instruction is a multi-cycle FPU op
- FpuLat_EX  in  LAT_W  total EX cycles the FPU op needs (N)
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  clear IF/ID, ID/EX and EX/MEM to a bubble
- FpuBusy  out  1  FSM is in BUSY
- FpuDone  out  1  FSM is in DONE; the FPU result is valid this cycle
- StallCycles  out  CNT_W  count of cycles with StallD=1

## Operation
- FSM states: IDLE, BUSY, DONE. Down-counter Cnt is LAT_W bits wide.
- FPU start condition (fstart): state==IDLE && FpuStart_EX && FpuLat_EX>=2.
  - FpuLat_EX of 0 or 1 means a single-cycle op and produces no action.
- FSM transitions:
  - IDLE, on fstart: load Cnt=N-2. Go to DONE if N==2, otherwise go to BUSY.
  - BUSY: if Cnt==1, go to DONE; otherwise Cnt=Cnt-1.
  - DONE: always go to IDLE. FpuStart_EX is ignored in DONE because it is still the same instruction.
- FPU hold (fhold) = fstart || state==BUSY.
  - While fhold: StallF=StallD=StallE=1 and FlushM=1 (a bubble enters MEM).
  - While fhold: FlushD=FlushE=0.
- Load-use (lu) = MemRead_EX && !fhold && ((RegWrite_EX && Rd_EX!=0) || RegWriteF_EX) && (Rd_EX==Rs1_D || Rd_EX==Rs2_D).
  - The comparison is class-agnostic and conservative.
  - Float f0 is a real register, so a float load to f0 still stalls. An integer load to x0 never stalls.
  - On lu: StallF=StallD=1 and FlushE=1.
- Branch: PCSrc_EX && !fhold gives FlushD=1 and FlushE=1.
  - lu and branch cannot both be true, since a load is not a branch. If both are asserted, outputs are the OR of the two.
- All stall and flush outputs are combinational from state, Cnt and the inputs.
- StallCycles increments by 1 on every cycle with StallD=1. It wraps modulo 2^CNT_W.
- On reset: state=IDLE, Cnt=0, StallCycles=0. The combinational outputs follow from that state.
  - A reset in the middle of BUSY abandons the op. No DONE pulse is produced.

## Timing
- Load-use costs exactly 1 stall cycle. The dependent instruction then gets the load data via WB forwarding.
- Branch costs 2 bubbles, both applied in the same cycle PCSrc_EX is high.
- FPU op with N>=2 entering EX at cycle t:
  - Stall outputs are high for cycles t through t+N-2, which is N-1 cycles.
  - FpuBusy is high for t+1 through t+N-2.
  - FpuDone is high at t+N-1, and the op advances to MEM at the end of that cycle.
- A back-to-back FPU op is accepted at t+N at the earliest, when the FSM is back in IDLE.
- Maximum supported latency is N=2^LAT_W-1.

## Test plan
- Int load-use: LW x5 in EX, ADD using x5 in ID -> StallF=StallD=FlushE=1 for 1 cycle; StallCycles +1. Repeat with Rd_EX=0 -> no stall.
- Float load-use: FLW f0 in EX, FADD reading f0 in ID -> 1-cycle stall.
- Branch: PCSrc_EX=1 -> FlushD=FlushE=1, no stall, StallCycles unchanged.
- FPU: FpuStart_EX=1 held with FpuLat_EX=5 -> stall and FlushM high 4 cycles, FpuBusy high 3 cycles, FpuDone 1 cycle, then IDLE. With N=2 -> 1 stall cycle, FpuDone next cycle. With N=1 -> nothing.
- Back-to-back: two FDIV ops with N=4 -> second accepted on the first cycle after DONE; 6 total stall cycles.
- Reset mid-op: reset during BUSY -> next cycle all outputs 0, FSM in IDLE, StallCycles=0. Also MemRead_EX with a match during BUSY -> FPU hold only, no FlushE.
